// File: rtl/audio_mix_pwm.sv
// Multi-channel audio mixer feeding a PWM DAC; one mixed sample is loaded per PWM period.
// Optional sticky underrun flag enabled with macro AUDIO_MIX_UNDERRUN_EN.
module audio_mix_pwm #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned SAMPLE_W = 4,
    parameter int unsigned PRESC_W  = 5
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_CH*SAMPLE_W-1:0]            samples,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_CH-1:0]                     ch_en,
    output logic                                  pwm,
    output logic [SAMPLE_W+$clog2(NUM_CH)-1:0]    duty_o,
    output logic                                  frame_strobe,
    output logic                                  underrun
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);
    localparam int unsigned SUM_W = SAMPLE_W + IDX_W;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                        state_q, state_d;
    logic [PRESC_W-1:0]            presc_q, presc_d;
    logic [SUM_W-1:0]              cnt_q, cnt_d;
    logic [SUM_W-1:0]              duty_q, duty_d;
    logic [SUM_W-1:0]              pending_q, pending_d;
    logic [SUM_W-1:0]              acc_q, acc_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [NUM_CH*SAMPLE_W-1:0]    samp_q, samp_d;
    logic                          pending_full_q, pending_full_d;
    logic                          pwm_q, pwm_d;
    logic                          frame_strobe_q, frame_strobe_d;

    logic                          tick;
    logic                          wrap;
    logic                          accept;
    logic                          last_ch;
    logic [SAMPLE_W-1:0]           addend;
    logic [SAMPLE_W-1:0]           ch_arr [NUM_CH];

    // PWM timebase
    always_comb begin
        tick    = (presc_q == '0);
        wrap    = tick && (cnt_q == '1);
        presc_d = presc_q + PRESC_W'(1);
        cnt_d   = tick ? cnt_q + SUM_W'(1) : cnt_q;
        pwm_d   = (cnt_q < duty_q);
        frame_strobe_d = wrap;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCUM;
            ACCUM:   if (last_ch) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; held low while reset is asserted
    always_comb begin
        in_ready = reset && (state_q == IDLE) && !pending_full_q;
        accept   = in_valid && in_ready;
        last_ch  = (state_q == ACCUM) && (idx_q == IDX_W'(NUM_CH - 1));
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            ch_arr[i] = samp_q[i*int'(SAMPLE_W) +: SAMPLE_W];
        end
        addend = ch_en[idx_q] ? ch_arr[idx_q] : '0;
    end

    // Mixer datapath and pending/duty hand-off; a write coinciding with a wrap is applied next wrap
    always_comb begin
        acc_d          = acc_q;
        idx_d          = idx_q;
        samp_d         = samp_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        duty_d         = duty_q;

        if (wrap && pending_full_q) begin
            duty_d         = pending_q;
            pending_full_d = 1'b0;
        end

        if (accept) begin
            samp_d = samples;
            acc_d  = '0;
            idx_d  = '0;
        end else if (state_q == ACCUM) begin
            acc_d = acc_q + SUM_W'(addend);
            idx_d = idx_q + IDX_W'(1);
            if (last_ch) begin
                pending_d      = acc_d;
                pending_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            duty_q         <= '0;
            pending_q      <= '0;
            acc_q          <= '0;
            idx_q          <= '0;
            samp_q         <= '0;
            pending_full_q <= 1'b0;
            pwm_q          <= 1'b0;
            frame_strobe_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            pending_q      <= pending_d;
            acc_q          <= acc_d;
            idx_q          <= idx_d;
            samp_q         <= samp_d;
            pending_full_q <= pending_full_d;
            pwm_q          <= pwm_d;
            frame_strobe_q <= frame_strobe_d;
        end
    end

`ifdef AUDIO_MIX_UNDERRUN_EN
    logic underrun_q, underrun_d;

    always_comb underrun_d = underrun_q || (wrap && !pending_full_q);

    always_ff @(posedge clock) begin
        if (!reset) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

    assign pwm          = pwm_q;
    assign duty_o       = duty_q;
    assign frame_strobe = frame_strobe_q;

endmodule

// File: tb/tb_audio_mix_pwm.sv
// Directed self-checking bench for audio_mix_pwm at default parameters.
module tb_audio_mix_pwm;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] samples = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ch_en = '0;
    logic        pwm;
    logic [5:0]  duty_o;
    logic        frame_strobe;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int cnt_a;
    int cnt_b;
    logic exp_urun;

    audio_mix_pwm dut (
        .clock        (clock),
        .reset        (reset),
        .samples      (samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ch_en        (ch_en),
        .pwm          (pwm),
        .duty_o       (duty_o),
        .frame_strobe (frame_strobe),
        .underrun     (underrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // n counts negedges since reset release; negedge n precedes posedge n
    task automatic step();
        @(negedge clock);
        n++;
    endtask

    task automatic advance_to(input int target);
        while (n < target) step();
    endtask

    task automatic hold_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
`ifdef AUDIO_MIX_UNDERRUN_EN
        exp_urun = 1'b1;
`else
        exp_urun = 1'b0;
`endif
        // Reset state
        hold_reset();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_duty", int'(duty_o), 0);
        check("rst_pwm", int'(pwm), 0);
        check("rst_strobe", int'(frame_strobe), 0);
        check("rst_underrun", int'(underrun), 0);

        // Full-scale mix: 4 x 15 = 60
        reset = 1'b1; n = 0;
        samples = 16'hFFFF; ch_en = 4'b1111; in_valid = 1'b1;
        #1 check("rel_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            in_valid = 1'b0;
            check("accum_in_ready", int'(in_ready), 0);
        end
        cnt_a = 0;
        while (n < 2016) begin
            step();
            cnt_a += int'(pwm);
        end
        check("duty0_pwm_low", cnt_a, 0);
        step();
        check("duty60", int'(duty_o), 60);
        check("wrap_strobe", int'(frame_strobe), 1);
        check("ready_after_load", int'(in_ready), 1);
        cnt_a = 0; cnt_b = 0;
        repeat (2048) begin
            step();
            cnt_a += int'(pwm);
            cnt_b += int'(frame_strobe);
        end
        check("pwm_high_60", cnt_a, 1920);
        check("strobe_per_period", cnt_b, 1);
        check("underrun_1st", int'(underrun), int'(exp_urun));

        // Masked mix: ch0 + ch2 = 3 + 7 = 10
        samples = {4'd9, 4'd7, 4'd5, 4'd3}; ch_en = 4'b0101; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        advance_to(6113);
        check("duty10", int'(duty_o), 10);

        // Three idle periods: duty holds, strobe once per 2048 clocks
        cnt_b = 0;
        repeat (3 * 2048) begin
            step();
            cnt_b += int'(frame_strobe);
        end
        check("idle_strobes", cnt_b, 3);
        check("idle_duty_hold", int'(duty_o), 10);
        check("idle_underrun", int'(underrun), int'(exp_urun));

        // Reset two clocks into ACCUM discards the mix
        hold_reset();
        reset = 1'b1; n = 0;
        samples = 16'hFFFF; ch_en = 4'b1111; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        step();
        check("midrst_in_ready", int'(in_ready), 0);
        reset = 1'b1; n = 0;
        #1 check("midrst_rel_ready", int'(in_ready), 1);
        check("midrst_duty", int'(duty_o), 0);
        check("midrst_underrun", int'(underrun), 0);

        // Pending write lands on the wrap edge: applied one period later
        samples = {4'd8, 4'd4, 4'd2, 4'd1}; ch_en = 4'b1111;
        advance_to(2012);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        advance_to(2017);
        check("coinc_duty_old", int'(duty_o), 0);
        check("coinc_strobe", int'(frame_strobe), 1);
        check("coinc_ready_low", int'(in_ready), 0);
        advance_to(4065);
        check("coinc_duty_new", int'(duty_o), 15);
        check("coinc_strobe2", int'(frame_strobe), 1);

        // in_valid held high: one accept per period
        samples = 16'h1111; in_valid = 1'b1;
        cnt_a = 0;
        while (n < 8161) begin
            if (in_valid && in_ready) cnt_a++;
            step();
        end
        in_valid = 1'b0;
        check("held_valid_accepts", cnt_a, 2);
        check("held_valid_duty", int'(duty_o), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
